// File: rtl/apb_master_if.sv
// Bundle of CPU-side request signals and APB bus signals for apb_master.
// The master modport is the initiator's view; the slave modport is the far side.
interface apb_master_if;
    logic        transfer;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        err;
    logic [31:0] rdata;

    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic [3:0]  PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA0;
    logic [31:0] PRDATA1;
    logic [31:0] PRDATA2;
    logic [31:0] PRDATA3;
    logic        PREADY0;
    logic        PREADY1;
    logic        PREADY2;
    logic        PREADY3;

    modport master (
        input  transfer, write, addr, wdata,
        input  PRDATA0, PRDATA1, PRDATA2, PRDATA3,
        input  PREADY0, PREADY1, PREADY2, PREADY3,
        output ready, err, rdata,
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );

    modport slave (
        output transfer, write, addr, wdata,
        output PRDATA0, PRDATA1, PRDATA2, PRDATA3,
        output PREADY0, PREADY1, PREADY2, PREADY3,
        input  ready, err, rdata,
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );
endinterface

// File: rtl/apb_master.sv
// APB initiator for four slaves: address decode, SETUP/ACCESS sequencing,
// wait-state watchdog, and a registered one-cycle completion pulse.
module apb_master #(
    parameter logic [15:0] BASE    = 16'h1000,
    parameter int unsigned TIMEOUT = 16
) (
    input logic          PCLK,
    input logic          PRESET,
    apb_master_if.master io_bus
);
    localparam int unsigned    WdW   = $clog2(TIMEOUT + 1);
    localparam logic [WdW-1:0] WdMax = WdW'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e         r_state, w_state_d;
    logic [1:0]     r_idx, w_idx_d;
    logic [31:0]    r_paddr, w_paddr_d;
    logic [31:0]    r_pwdata, w_pwdata_d;
    logic           r_pwrite, w_pwrite_d;
    logic [3:0]     r_psel, w_psel_d;
    logic           r_penable, w_penable_d;
    logic           r_ready, w_ready_d;
    logic           r_err, w_err_d;
    logic [31:0]    r_rdata, w_rdata_d;
    logic [WdW-1:0] r_wdog, w_wdog_d;

    logic           w_valid;
    logic           w_pready_sel;
    logic [31:0]    w_prdata_sel;
    logic           w_timeout;

    assign w_valid   = (io_bus.addr[31:16] == BASE) && (io_bus.addr[15:14] == 2'b00);
    assign w_timeout = (r_wdog == WdMax);

    // Only the latched slave's response is observed.
    always_comb begin
        w_pready_sel = 1'b0;
        w_prdata_sel = '0;
        unique case (r_idx)
            2'd0: begin w_pready_sel = io_bus.PREADY0; w_prdata_sel = io_bus.PRDATA0; end
            2'd1: begin w_pready_sel = io_bus.PREADY1; w_prdata_sel = io_bus.PRDATA1; end
            2'd2: begin w_pready_sel = io_bus.PREADY2; w_prdata_sel = io_bus.PRDATA2; end
            2'd3: begin w_pready_sel = io_bus.PREADY3; w_prdata_sel = io_bus.PRDATA3; end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state   <= StIdle;
            r_idx     <= '0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pwrite  <= 1'b0;
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
            r_wdog    <= '0;
        end else begin
            r_state   <= w_state_d;
            r_idx     <= w_idx_d;
            r_paddr   <= w_paddr_d;
            r_pwdata  <= w_pwdata_d;
            r_pwrite  <= w_pwrite_d;
            r_psel    <= w_psel_d;
            r_penable <= w_penable_d;
            r_ready   <= w_ready_d;
            r_err     <= w_err_d;
            r_rdata   <= w_rdata_d;
            r_wdog    <= w_wdog_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:   if (io_bus.transfer && w_valid) w_state_d = StSetup;
            StSetup:  w_state_d = StAccess;
            StAccess: if (w_pready_sel || w_timeout) w_state_d = StIdle;
            default:  w_state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs; every output leaves a flop.
    always_comb begin
        w_idx_d     = r_idx;
        w_paddr_d   = r_paddr;
        w_pwdata_d  = r_pwdata;
        w_pwrite_d  = r_pwrite;
        w_psel_d    = r_psel;
        w_penable_d = r_penable;
        w_ready_d   = 1'b0;
        w_err_d     = 1'b0;
        w_rdata_d   = r_rdata;
        w_wdog_d    = r_wdog;
        unique case (r_state)
            StIdle: begin
                w_psel_d    = '0;
                w_penable_d = 1'b0;
                if (io_bus.transfer) begin
                    if (w_valid) begin
                        w_idx_d    = io_bus.addr[13:12];
                        w_paddr_d  = io_bus.addr;
                        w_pwdata_d = io_bus.wdata;
                        w_pwrite_d = io_bus.write;
                        w_psel_d   = 4'b0001 << io_bus.addr[13:12];
                        w_wdog_d   = '0;
                    end else begin
                        w_ready_d = 1'b1;
                        w_err_d   = 1'b1;
                        w_rdata_d = '0;
                    end
                end
            end
            StSetup: begin
                w_penable_d = 1'b1;
                w_wdog_d    = r_wdog + 1'b1;
            end
            StAccess: begin
                if (w_pready_sel) begin
                    w_psel_d    = '0;
                    w_penable_d = 1'b0;
                    w_ready_d   = 1'b1;
                    w_rdata_d   = r_pwrite ? 32'h0 : w_prdata_sel;
                end else if (w_timeout) begin
                    w_psel_d    = '0;
                    w_penable_d = 1'b0;
                    w_ready_d   = 1'b1;
                    w_err_d     = 1'b1;
                    w_rdata_d   = '0;
                end else if (r_wdog != WdMax) begin
                    w_wdog_d = r_wdog + 1'b1;
                end
            end
            default: begin
                w_psel_d    = '0;
                w_penable_d = 1'b0;
            end
        endcase
    end

    assign io_bus.PADDR   = r_paddr;
    assign io_bus.PWDATA  = r_pwdata;
    assign io_bus.PWRITE  = r_pwrite;
    assign io_bus.PSEL    = r_psel;
    assign io_bus.PENABLE = r_penable;
    assign io_bus.ready   = r_ready;
    assign io_bus.err     = r_err;
    assign io_bus.rdata   = r_rdata;
endmodule
